// File: rtl/sr_bank_pkg.sv
// Shared encodings for the clocked SR flop bank: S=R=1 resolution policies.
package sr_bank_pkg;
  localparam int MODE_RST_DOM = 0;
  localparam int MODE_SET_DOM = 1;
  localparam int MODE_TOGGLE  = 2;
  localparam int MODE_HOLD    = 3;
endpackage

// File: rtl/sr_cell.sv
// One SR channel: registered Q bit and registered conflict pulse.
// conflict_nxt exposes the pre-register conflict so the top can count it on the same edge.
module sr_cell
  import sr_bank_pkg::*;
#(
  parameter int   CONFLICT_MODE = MODE_TOGGLE,
  parameter logic RST_VAL       = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic load,
  input  logic d,
  input  logic s,
  input  logic r,
  output logic q,
  output logic conflict,
  output logic conflict_nxt
);

  logic q_q, q_d;
  logic conflict_q, conflict_d;

  always_comb begin
    q_d        = q_q;
    conflict_d = en & ~load & s & r;
    if (load) begin
      q_d = d;
    end else if (en) begin
      case ({s, r})
        2'b01:   q_d = 1'b0;
        2'b10:   q_d = 1'b1;
        2'b11: begin
          case (CONFLICT_MODE)
            MODE_RST_DOM: q_d = 1'b0;
            MODE_SET_DOM: q_d = 1'b1;
            MODE_TOGGLE:  q_d = ~q_q;
            default:      q_d = q_q;
          endcase
        end
        default: q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q        <= RST_VAL;
      conflict_q <= 1'b0;
    end else begin
      q_q        <= q_d;
      conflict_q <= conflict_d;
    end
  end

  assign q            = q_q;
  assign conflict     = conflict_q;
  assign conflict_nxt = conflict_d;

endmodule

// File: rtl/sr_flop_bank.sv
// Bank of WIDTH clocked SR flops with a selectable S=R=1 policy plus
// conflict monitoring: per-channel pulses, a sticky flag and a saturating counter.
module sr_flop_bank
  import sr_bank_pkg::*;
#(
  parameter int               WIDTH         = 8,
  parameter int               CONFLICT_MODE = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE   = {WIDTH{1'b0}},
  parameter int               CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] R,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_bar,
  output logic [WIDTH-1:0] conflict,
  output logic             conflict_sticky,
  output logic [CNT_W-1:0] conflict_cnt
);

  generate
    if (CONFLICT_MODE < 0 || CONFLICT_MODE > 3 || WIDTH < 1 || CNT_W < 1) begin : g_bad_param
      $error("sr_flop_bank: illegal parameters (CONFLICT_MODE 0..3, WIDTH>=1, CNT_W>=1)");
    end
  endgenerate

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0] conflict_nxt;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
      sr_cell #(
        .CONFLICT_MODE(CONFLICT_MODE),
        .RST_VAL      (RESET_VALUE[gi])
      ) u_cell (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .load        (load),
        .d           (d[gi]),
        .s           (S[gi]),
        .r           (R[gi]),
        .q           (Q[gi]),
        .conflict    (conflict[gi]),
        .conflict_nxt(conflict_nxt[gi])
      );
    end
  endgenerate

  assign Q_bar = ~Q;

  logic             any_conflict;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign any_conflict = |conflict_nxt;

  // clr_flags beats a coincident conflict for both sticky and count
  always_comb begin
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    if (clr_flags) begin
      sticky_d = 1'b0;
      cnt_d    = '0;
    end else if (any_conflict) begin
      sticky_d = 1'b1;
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign conflict_sticky = sticky_q;
  assign conflict_cnt    = cnt_q;

endmodule

// File: tb/tb_sr_flop_bank.sv
// Drives one stimulus stream into four banks (one per conflict policy) and
// compares every output against a bitwise reference model of the SR rules.
module tb_sr_flop_bank;
  localparam logic [7:0] RV = 8'hA5;

  logic       clk = 1'b0;
  logic       rst, en, load, clr_flags;
  logic [7:0] S, R, d;

  logic [7:0] q_o   [4];
  logic [7:0] qb_o  [4];
  logic [7:0] cf_o  [4];
  logic       stk_o [4];
  logic [1:0] cnt_o [4];

  always #5 clk = ~clk;

  generate
    for (genvar m = 0; m < 4; m++) begin : g_dut
      sr_flop_bank #(
        .WIDTH(8), .CONFLICT_MODE(m), .RESET_VALUE(RV), .CNT_W(2)
      ) u_dut (
        .clk(clk), .rst(rst), .en(en), .S(S), .R(R), .load(load), .d(d),
        .clr_flags(clr_flags), .Q(q_o[m]), .Q_bar(qb_o[m]), .conflict(cf_o[m]),
        .conflict_sticky(stk_o[m]), .conflict_cnt(cnt_o[m])
      );
    end
  endgenerate

  logic [7:0] mq [4];
  logic [7:0] mcf [4];
  logic       mstk [4];
  int         mcnt [4];
  int vectors = 0;
  int miscompares = 0;

  task automatic model_reset();
    for (int m = 0; m < 4; m++) begin
      mq[m] = RV; mcf[m] = 8'h00; mstk[m] = 1'b0; mcnt[m] = 0;
    end
  endtask

  task automatic model_edge();
    logic [7:0] pol, both;
    for (int m = 0; m < 4; m++) begin
      both   = (en && !load) ? (S & R) : 8'h00;
      mcf[m] = both;
      case (m)
        0: pol = 8'h00;
        1: pol = 8'hFF;
        2: pol = ~mq[m];
        default: pol = mq[m];
      endcase
      if (load) mq[m] = d;
      else if (en) mq[m] = (mq[m] & ~(S | R)) | (S & ~R) | (S & R & pol);
      if (clr_flags) begin
        mstk[m] = 1'b0; mcnt[m] = 0;
      end else if (both != 8'h00) begin
        mstk[m] = 1'b1;
        if (mcnt[m] < 3) mcnt[m] = mcnt[m] + 1;
      end
    end
  endtask

  task automatic chk8(string tag, int m, logic [7:0] obs, logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s mode%0d observed=%h expected=%h", tag, m, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    for (int m = 0; m < 4; m++) begin
      chk8({tag, ".Q"}, m, q_o[m], mq[m]);
      chk8({tag, ".Q_bar"}, m, qb_o[m], ~mq[m]);
      chk8({tag, ".conflict"}, m, cf_o[m], mcf[m]);
      chk8({tag, ".sticky"}, m, {7'd0, stk_o[m]}, {7'd0, mstk[m]});
      chk8({tag, ".cnt"}, m, {6'd0, cnt_o[m]}, 8'(mcnt[m]));
    end
  endtask

  // one rising edge with the currently applied inputs, then check 1 time unit later
  task automatic cyc(string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic drive(logic e, logic [7:0] s, logic [7:0] r, logic l, logic [7:0] dd, logic c);
    en = e; S = s; R = r; load = l; d = dd; clr_flags = c;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 8'h00, 8'h00, 0, 8'h00, 0);
    model_reset();
    #3;
    check_all("reset");
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // basic SR from 00
    drive(0, 8'h00, 8'h00, 1, 8'h00, 0); cyc("load00");
    drive(1, 8'h0F, 8'hF0, 0, 8'h00, 0); cyc("basic_sr");
    drive(1, 8'h00, 8'h00, 0, 8'h00, 0);
    for (int i = 0; i < 3; i++) cyc("hold");
    drive(0, 8'hFF, 8'h00, 0, 8'h00, 0); cyc("en_off");

    // conflict policies from 0F
    drive(0, 8'h00, 8'h00, 1, 8'h0F, 1); cyc("load0F_clr");
    drive(1, 8'hFF, 8'hFF, 0, 8'h00, 0); cyc("conflict");
    drive(0, 8'h00, 8'h00, 0, 8'h00, 0); cyc("conflict_after");

    // load overrides en and S/R
    drive(1, 8'hFF, 8'hFF, 1, 8'h3C, 0); cyc("load_prio");

    // saturation with CNT_W=2
    drive(0, 8'h00, 8'h00, 0, 8'h00, 1); cyc("clr");
    drive(1, 8'h81, 8'h81, 0, 8'h00, 0);
    for (int i = 0; i < 5; i++) cyc("saturate");
    drive(1, 8'h81, 8'h81, 0, 8'h00, 1); cyc("clr_vs_conflict");

    // async reset asserted mid-cycle
    drive(1, 8'h0F, 8'h00, 0, 8'h00, 0);
    #3; rst = 1'b1; #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk); #1; check_all("rst_held");
    @(negedge clk); rst = 1'b0;

    // reset mid-toggle
    drive(1, 8'hFF, 8'hFF, 0, 8'h00, 0);
    for (int i = 0; i < 3; i++) cyc("toggle");
    #2; rst = 1'b1; #1;
    model_reset();
    check_all("rst_toggle");
    @(negedge clk); rst = 1'b0;
    cyc("toggle_resume");

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom),
            $urandom_range(0, 9) == 0, 8'($urandom), $urandom_range(0, 11) == 0);
      cyc("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
